// File: rtl/tl_pkg.sv
// Shared definitions for the TileLink-style slave responder.
// - Opcode constants for the A and D channels.
// - Bit positions of every field packed into a_channel and d_channel.
// - FSM state encoding.
package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  // a_channel field positions
  localparam int A_OP_MSB    = 54;
  localparam int A_OP_LSB    = 52;
  localparam int A_PARAM_MSB = 51;
  localparam int A_PARAM_LSB = 49;
  localparam int A_SIZE_MSB  = 48;
  localparam int A_SIZE_LSB  = 46;
  localparam int A_SRC_MSB   = 45;
  localparam int A_SRC_LSB   = 44;
  localparam int A_ADDR_MSB  = 43;
  localparam int A_ADDR_LSB  = 34;
  localparam int A_DATA_MSB  = 33;
  localparam int A_DATA_LSB  = 2;
  localparam int A_VALID     = 1;

  // d_channel field positions
  localparam int D_OP_MSB   = 39;
  localparam int D_OP_LSB   = 37;
  localparam int D_SRC_MSB  = 36;
  localparam int D_SRC_LSB  = 35;
  localparam int D_ERR      = 34;
  localparam int D_DATA_MSB = 33;
  localparam int D_DATA_LSB = 2;
  localparam int D_VALID    = 1;
  localparam int D_AREADY   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/tl_slave_mem.sv
// Word memory behind the responder.
// - clk_i   : write clock
// - we_i    : write enable (caller guarantees waddr_i is in range)
// - waddr_i : write word address
// - wdata_i : write data
// - raddr_i : read word address (combinational read)
// - rdata_o : read data
// Contents are deliberately not reset.
module tl_slave_mem #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tl_slave_responder.sv
// A-channel responder: services Get / PutFullData from a local word memory
// and answers on the D channel with AccessAck / AccessAckData plus error.
// - clk       : rising-edge clock
// - reset     : asynchronous, active-low
// - a_channel : packed request {op,param,size,source,address,data,valid,unused}
// - d_channel : packed response {op,source,error,data,d_valid,a_ready}
// - proto_err : sticky, set when a_valid arrives while a_ready is low
module tl_slave_responder
  import tl_pkg::*;
#(
  parameter int A_W       = 55,
  parameter int D_W       = 40,
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024,
  parameter int RESP_LAT  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [A_W-1:0] a_channel,
  output logic [D_W-1:0] d_channel,
  output logic           proto_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [1:0]      LAT_L   = 2'(RESP_LAT);

  // request fields
  logic [2:0]        a_op;
  logic [1:0]        a_src;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_data;
  logic              a_valid;
  logic              unused_a;

  assign a_op     = a_channel[A_OP_MSB:A_OP_LSB];
  assign a_src    = a_channel[A_SRC_MSB:A_SRC_LSB];
  assign a_addr   = a_channel[A_ADDR_MSB:A_ADDR_LSB];
  assign a_data   = a_channel[A_DATA_MSB:A_DATA_LSB];
  assign a_valid  = a_channel[A_VALID];
  assign unused_a = ^{a_channel[A_PARAM_MSB:A_SIZE_LSB], a_channel[0]};

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        dop_q, dop_d;
  logic [1:0]        dsrc_q, dsrc_d;
  logic              derr_q, derr_d;
  logic [31:0]       ddata_q, ddata_d;
  logic              perr_q, perr_d;

  logic              a_ready, accept;
  logic              mem_we;
  logic              load_resp;
  logic [2:0]        rsp_op;
  logic [1:0]        rsp_src;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_in_range;
  logic [31:0]       rdata;

  assign a_ready = (state_q != ST_WAIT);
  assign accept  = a_valid && a_ready;

  // Read port follows the request that is turning into a response this edge:
  // the live request for zero latency, the latched one when leaving WAIT.
  tl_slave_mem #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (32)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (a_addr),
    .wdata_i (a_data),
    .raddr_i (rsp_addr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    src_d     = src_q;
    addr_d    = addr_q;
    perr_d    = perr_q;
    mem_we    = 1'b0;
    load_resp = 1'b0;
    rsp_op    = op_q;
    rsp_src   = src_q;
    rsp_addr  = addr_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (state_q == ST_RESP) state_d = ST_IDLE;
        if (accept) begin
          op_d   = a_op;
          src_d  = a_src;
          addr_d = a_addr;
          cnt_d  = LAT_L;
          // Writes commit on the accept edge so a later reset cannot undo them.
          mem_we = (a_op == PUT_FULL) && ({1'b0, a_addr} < DEPTH_L);
          if (RESP_LAT > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_RESP;
            load_resp = 1'b1;
            rsp_op    = a_op;
            rsp_src   = a_src;
            rsp_addr  = a_addr;
          end
        end
      end
      ST_WAIT: begin
        // Master violated the handshake; the request is dropped.
        if (a_valid) perr_d = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d   = ST_RESP;
          load_resp = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response decode; D fields only change when a response is loaded and
  // otherwise hold their last values.
  assign rsp_in_range = ({1'b0, rsp_addr} < DEPTH_L);

  always_comb begin
    dop_d   = dop_q;
    dsrc_d  = dsrc_q;
    derr_d  = derr_q;
    ddata_d = ddata_q;
    if (load_resp) begin
      dsrc_d  = rsp_src;
      ddata_d = '0;
      case (rsp_op)
        GET: begin
          dop_d  = ACK_DATA;
          derr_d = !rsp_in_range;
          if (rsp_in_range) ddata_d = rdata;
        end
        PUT_FULL: begin
          dop_d  = ACK;
          derr_d = !rsp_in_range;
        end
        default: begin
          dop_d  = ACK;
          derr_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      dop_q   <= '0;
      dsrc_q  <= '0;
      derr_q  <= 1'b0;
      ddata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      dop_q   <= dop_d;
      dsrc_q  <= dsrc_d;
      derr_q  <= derr_d;
      ddata_q <= ddata_d;
      perr_q  <= perr_d;
    end
  end

  assign d_channel = {dop_q, dsrc_q, derr_q, ddata_q, (state_q == ST_RESP), a_ready};
  assign proto_err = perr_q;

endmodule

// File: tb/tb_tl_slave_responder.sv
// Directed bench: u_dut0 has zero response latency, u_dut2 has two wait
// cycles; both implement 512 words so 0x3FF is out of range.
module tb_tl_slave_responder;

  logic        clk;
  logic        reset;
  logic [54:0] a_ch0, a_ch2;
  logic [39:0] d_ch0, d_ch2;
  logic        perr0, perr2;

  int n_chk;
  int n_fail;

  tl_slave_responder #(.MEM_DEPTH(512), .RESP_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .a_channel(a_ch0), .d_channel(d_ch0), .proto_err(perr0));

  tl_slave_responder #(.MEM_DEPTH(512), .RESP_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .a_channel(a_ch2), .d_channel(d_ch2), .proto_err(perr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [54:0] req(input logic [2:0] op, input logic [1:0] src,
                                      input logic [9:0] addr, input logic [31:0] data);
    return {op, 3'd0, 3'd0, src, addr, data, 1'b1, 1'b0};
  endfunction

  // expected {d_opcode, d_source, d_error, d_data}
  function automatic logic [37:0] rsp(input logic [2:0] op, input logic [1:0] src,
                                      input logic err, input logic [31:0] data);
    return {op, src, err, data};
  endfunction

  // Zero-latency transaction on u_dut0: response in the cycle after accept.
  task automatic txn0(input string tag, input logic [54:0] r, input logic [37:0] exp);
    @(negedge clk) a_ch0 = r;
    @(negedge clk) a_ch0 = '0;
    chk({tag, ".dv"}, 64'(d_ch0[1:0]), 64'h3);
    chk({tag, ".rsp"}, 64'(d_ch0[39:2]), 64'(exp));
    @(negedge clk);
    chk({tag, ".idle"}, 64'(d_ch0[1:0]), 64'h1);
  endtask

  // Two-wait transaction on u_dut2.
  task automatic txn2(input string tag, input logic [54:0] r, input logic [37:0] exp);
    @(negedge clk) a_ch2 = r;
    @(negedge clk) a_ch2 = '0;
    chk({tag, ".w1"}, 64'(d_ch2[1:0]), 64'h0);
    @(negedge clk);
    chk({tag, ".w2"}, 64'(d_ch2[1:0]), 64'h0);
    @(negedge clk);
    chk({tag, ".dv"}, 64'(d_ch2[1:0]), 64'h3);
    chk({tag, ".rsp"}, 64'(d_ch2[39:2]), 64'(exp));
    @(negedge clk);
    chk({tag, ".idle"}, 64'(d_ch2[1:0]), 64'h1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    a_ch0  = '0;
    a_ch2  = '0;
    #12;
    chk("rst.d0", 64'(d_ch0), 64'h1);
    chk("rst.pe0", 64'(perr0), 64'h0);
    chk("rst.d2", 64'(d_ch2), 64'h1);
    @(negedge clk) reset = 1'b1;

    // ---- zero latency ----
    txn0("put5", req(3'd0, 2'd1, 10'h005, 32'hDEADBEEF), rsp(3'd0, 2'd1, 1'b0, 32'h0));
    txn0("get5", req(3'd4, 2'd2, 10'h005, 32'h0), rsp(3'd1, 2'd2, 1'b0, 32'hDEADBEEF));
    chk("hold", 64'(d_ch0[33:2]), 64'hDEADBEEF);
    txn0("get3ff", req(3'd4, 2'd3, 10'h3FF, 32'h0), rsp(3'd1, 2'd3, 1'b1, 32'h0));
    txn0("put1ff", req(3'd0, 2'd0, 10'h1FF, 32'h11111111), rsp(3'd0, 2'd0, 1'b0, 32'h0));
    txn0("put3ff", req(3'd0, 2'd1, 10'h3FF, 32'h22222222), rsp(3'd0, 2'd1, 1'b1, 32'h0));
    txn0("get1ff", req(3'd4, 2'd1, 10'h1FF, 32'h0), rsp(3'd1, 2'd1, 1'b0, 32'h11111111));
    txn0("ppart", req(3'd1, 2'd2, 10'h005, 32'h1), rsp(3'd0, 2'd2, 1'b1, 32'h0));
    txn0("op7", req(3'd7, 2'd3, 10'h005, 32'h2), rsp(3'd0, 2'd3, 1'b1, 32'h0));
    txn0("get5b", req(3'd4, 2'd0, 10'h005, 32'h0), rsp(3'd1, 2'd0, 1'b0, 32'hDEADBEEF));
    txn0("put6", req(3'd0, 2'd0, 10'h006, 32'hCAFEF00D), rsp(3'd0, 2'd0, 1'b0, 32'h0));

    // back-to-back: Get 5, Get 6, Put 7, Get 7 each accepted in the previous RESP cycle
    @(negedge clk) a_ch0 = req(3'd4, 2'd1, 10'h005, 32'h0);
    @(negedge clk);
    chk("b2b1.dv", 64'(d_ch0[1:0]), 64'h3);
    chk("b2b1.rsp", 64'(d_ch0[39:2]), 64'(rsp(3'd1, 2'd1, 1'b0, 32'hDEADBEEF)));
    a_ch0 = req(3'd4, 2'd2, 10'h006, 32'h0);
    @(negedge clk);
    chk("b2b2.dv", 64'(d_ch0[1:0]), 64'h3);
    chk("b2b2.rsp", 64'(d_ch0[39:2]), 64'(rsp(3'd1, 2'd2, 1'b0, 32'hCAFEF00D)));
    a_ch0 = req(3'd0, 2'd3, 10'h007, 32'h00000077);
    @(negedge clk);
    chk("b2b3.dv", 64'(d_ch0[1:0]), 64'h3);
    chk("b2b3.rsp", 64'(d_ch0[39:2]), 64'(rsp(3'd0, 2'd3, 1'b0, 32'h0)));
    a_ch0 = req(3'd4, 2'd0, 10'h007, 32'h0);
    @(negedge clk) a_ch0 = '0;
    chk("b2b4.dv", 64'(d_ch0[1:0]), 64'h3);
    chk("b2b4.rsp", 64'(d_ch0[39:2]), 64'(rsp(3'd1, 2'd0, 1'b0, 32'h77)));
    @(negedge clk);
    chk("b2b.idle", 64'(d_ch0[1:0]), 64'h1);
    chk("b2b.pe", 64'(perr0), 64'h0);

    // ---- two-cycle latency ----
    txn2("l2put", req(3'd0, 2'd1, 10'h010, 32'hBEEF0001), rsp(3'd0, 2'd1, 1'b0, 32'h0));
    chk("l2.pe0", 64'(perr2), 64'h0);
    // Get with an illegal a_valid pulse during WAIT
    @(negedge clk) a_ch2 = req(3'd4, 2'd2, 10'h010, 32'h0);
    @(negedge clk) a_ch2 = req(3'd0, 2'd3, 10'h010, 32'h00000BAD);
    chk("l2w.ar", 64'(d_ch2[1:0]), 64'h0);
    @(negedge clk) a_ch2 = '0;
    chk("l2w.w2", 64'(d_ch2[1:0]), 64'h0);
    chk("l2w.pe", 64'(perr2), 64'h1);
    @(negedge clk);
    chk("l2w.dv", 64'(d_ch2[1:0]), 64'h3);
    chk("l2w.rsp", 64'(d_ch2[39:2]), 64'(rsp(3'd1, 2'd2, 1'b0, 32'hBEEF0001)));
    @(negedge clk);
    chk("l2w.idle", 64'(d_ch2[1:0]), 64'h1);
    txn2("l2get", req(3'd4, 2'd3, 10'h010, 32'h0), rsp(3'd1, 2'd3, 1'b0, 32'hBEEF0001));
    chk("l2.pesticky", 64'(perr2), 64'h1);

    // ---- async reset during WAIT ----
    @(negedge clk) a_ch2 = req(3'd4, 2'd1, 10'h010, 32'h0);
    @(negedge clk) a_ch2 = '0;
    chk("rw.wait", 64'(d_ch2[1:0]), 64'h0);
    #2 reset = 1'b0;
    #1;
    chk("rw.async", 64'(d_ch2[1:0]), 64'h1);
    chk("rw.pe", 64'(perr2), 64'h0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rw.nodv%0d", i), 64'(d_ch2[1]), 64'h0);
    end
    txn2("rwget", req(3'd4, 2'd2, 10'h010, 32'h0), rsp(3'd1, 2'd2, 1'b0, 32'hBEEF0001));
    chk("rw.pe2", 64'(perr2), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
